// File: rtl/dmem_port_arbiter_if.sv
// Signal bundle between the data-memory port arbiter, its two requesters
// (core load/store path and debug/loader) and the shared memory port.
interface dmem_port_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        cpu_stall;

    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [3:0]  dbg_wstrb;
    logic        dbg_ready;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        output cpu_ready, cpu_rvalid, cpu_rdata, cpu_err, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb,
        output dbg_ready, dbg_rvalid, dbg_rdata, dbg_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_err, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb,
        input  dbg_ready, dbg_rvalid, dbg_rdata, dbg_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core and a
// debug/loader port, with command/response sequencing and a bounded timeout.
module dmem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_port_arbiter_if.master  bus
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_RESP = 2'd2} state_e;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DBG = 2'd2} owner_e;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Reads never carry write data or strobes onto the memory bus.
    function automatic logic [31:0] cmd_wdata(input logic we, input logic [31:0] wdata);
        return we ? wdata : 32'h0000_0000;
    endfunction

    function automatic logic [3:0] cmd_wstrb(input logic we, input logic [3:0] wstrb);
        return we ? wstrb : 4'h0;
    endfunction

    state_e      state_r,      state_s;
    owner_e      owner_r,      owner_s;
    owner_e      last_owner_r, last_owner_s;
    logic [CNT_W-1:0] cnt_r,   cnt_s;
    logic        mem_req_r,    mem_req_s;
    logic        mem_we_r,     mem_we_s;
    logic [31:0] mem_addr_r,   mem_addr_s;
    logic [31:0] mem_wdata_r,  mem_wdata_s;
    logic [3:0]  mem_wstrb_r,  mem_wstrb_s;

    logic        done_s;
    logic        rd_done_s;
    logic        timeout_s;
    logic        pick_cpu_s;
    logic        pick_dbg_s;
    logic        cpu_ready_s, cpu_rvalid_s, cpu_err_s;
    logic        dbg_ready_s, dbg_rvalid_s, dbg_err_s;
    logic [31:0] cpu_rdata_s, dbg_rdata_s;

    // Completion / timeout detection for the access in flight.
    always_comb begin
        done_s    = 1'b0;
        rd_done_s = 1'b0;
        if (state_r == ST_CMD) begin
            done_s = bus.mem_gnt & mem_we_r;
        end else if (state_r == ST_RESP) begin
            done_s    = bus.mem_rvalid;
            rd_done_s = bus.mem_rvalid;
        end else begin
            done_s    = 1'b0;
            rd_done_s = 1'b0;
        end
        timeout_s = (state_r != ST_IDLE) && (cnt_r == CNT_LAST) && !done_s;
    end

    // Round-robin pick: on a tie the requester that did not go last wins.
    always_comb begin
        pick_cpu_s = bus.cpu_req & (~bus.dbg_req | (last_owner_r == OWN_DBG));
        pick_dbg_s = bus.dbg_req & ~pick_cpu_s;
    end

    // Next-state and command-register update.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        cnt_s        = cnt_r;
        mem_req_s    = mem_req_r;
        mem_we_s     = mem_we_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        mem_wstrb_s  = mem_wstrb_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_cpu_s) begin
                    state_s      = ST_CMD;
                    owner_s      = OWN_CPU;
                    last_owner_s = OWN_CPU;
                    cnt_s        = '0;
                    mem_req_s    = 1'b1;
                    mem_we_s     = bus.cpu_we;
                    mem_addr_s   = bus.cpu_addr;
                    mem_wdata_s  = cmd_wdata(bus.cpu_we, bus.cpu_wdata);
                    mem_wstrb_s  = cmd_wstrb(bus.cpu_we, bus.cpu_wstrb);
                end else if (pick_dbg_s) begin
                    state_s      = ST_CMD;
                    owner_s      = OWN_DBG;
                    last_owner_s = OWN_DBG;
                    cnt_s        = '0;
                    mem_req_s    = 1'b1;
                    mem_we_s     = bus.dbg_we;
                    mem_addr_s   = bus.dbg_addr;
                    mem_wdata_s  = cmd_wdata(bus.dbg_we, bus.dbg_wdata);
                    mem_wstrb_s  = cmd_wstrb(bus.dbg_we, bus.dbg_wstrb);
                end else begin
                    state_s   = ST_IDLE;
                    mem_req_s = 1'b0;
                end
            end
            ST_CMD: begin
                cnt_s = cnt_r + CNT_ONE;
                if (done_s || timeout_s) begin
                    state_s   = ST_IDLE;
                    owner_s   = OWN_NONE;
                    mem_req_s = 1'b0;
                end else if (bus.mem_gnt) begin
                    state_s   = ST_RESP;
                    mem_req_s = 1'b0;
                end else begin
                    state_s   = ST_CMD;
                end
            end
            ST_RESP: begin
                cnt_s     = cnt_r + CNT_ONE;
                mem_req_s = 1'b0;
                if (done_s || timeout_s) begin
                    state_s = ST_IDLE;
                    owner_s = OWN_NONE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                owner_s   = OWN_NONE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State and command registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_NONE;
            last_owner_r <= OWN_DBG;
            cnt_r        <= '0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            mem_wdata_r  <= 32'h0000_0000;
            mem_wstrb_r  <= 4'h0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            cnt_r        <= cnt_s;
            mem_req_r    <= mem_req_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            mem_wstrb_r  <= mem_wstrb_s;
        end
    end

    // Steer completion pulses to the owner only; nothing fires while in reset.
    always_comb begin
        cpu_ready_s  = 1'b0;
        cpu_rvalid_s = 1'b0;
        cpu_err_s    = 1'b0;
        cpu_rdata_s  = 32'h0000_0000;
        dbg_ready_s  = 1'b0;
        dbg_rvalid_s = 1'b0;
        dbg_err_s    = 1'b0;
        dbg_rdata_s  = 32'h0000_0000;
        if (reset) begin
            cpu_ready_s = 1'b0;
            dbg_ready_s = 1'b0;
        end else if (owner_r == OWN_CPU) begin
            cpu_ready_s  = done_s | timeout_s;
            cpu_rvalid_s = rd_done_s;
            cpu_err_s    = timeout_s;
            cpu_rdata_s  = rd_done_s ? bus.mem_rdata : 32'h0000_0000;
        end else if (owner_r == OWN_DBG) begin
            dbg_ready_s  = done_s | timeout_s;
            dbg_rvalid_s = rd_done_s;
            dbg_err_s    = timeout_s;
            dbg_rdata_s  = rd_done_s ? bus.mem_rdata : 32'h0000_0000;
        end else begin
            cpu_ready_s = 1'b0;
            dbg_ready_s = 1'b0;
        end
    end

    assign bus.cpu_ready  = cpu_ready_s;
    assign bus.cpu_rvalid = cpu_rvalid_s;
    assign bus.cpu_err    = cpu_err_s;
    assign bus.cpu_rdata  = cpu_rdata_s;
    assign bus.cpu_stall  = bus.cpu_req & ~cpu_ready_s;
    assign bus.dbg_ready  = dbg_ready_s;
    assign bus.dbg_rvalid = dbg_rvalid_s;
    assign bus.dbg_err    = dbg_err_s;
    assign bus.dbg_rdata  = dbg_rdata_s;
    assign bus.mem_req    = mem_req_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.mem_wstrb  = mem_wstrb_r;

endmodule
